// File: rtl/arty_mig_pkg.sv
// Shared constants, FSM state encoding and the self-test data pattern for the
// Arty DDR3 self-test top.
package arty_mig_pkg;

  localparam int APP_ADDR_W_DEF = 28;
  localparam int APP_DATA_W_DEF = 128;

  localparam logic [2:0] APP_CMD_WR = 3'b000;
  localparam logic [2:0] APP_CMD_RD = 3'b001;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    RD      = 3'd2,
    WAIT_RD = 3'd3,
    DONE    = 3'd4
  } tgen_state_t;

  // One 32-bit word replicated across the 128-bit app beat (x16, 4:1, BL8).
  function automatic logic [127:0] pattern_word(input logic [31:0] seed,
                                                input logic [31:0] k);
    logic [31:0] w;
    w = seed + k;
    return {4{w}};
  endfunction

endpackage

// File: rtl/arty_mig_tgen.sv
// Self-test traffic engine: writes TEST_WORDS patterned bursts, reads them
// back, checks returned beats in order and raises sticky pass/fail flags.
module arty_mig_tgen
  import arty_mig_pkg::*;
#(
  parameter int          APP_ADDR_W = APP_ADDR_W_DEF,
  parameter int          APP_DATA_W = APP_DATA_W_DEF,
  parameter int          TEST_WORDS = 16,
  parameter logic [31:0] SEED       = 32'hA5A5_0000
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_calib,
  input  logic                  i_app_rdy,
  input  logic                  i_app_wdf_rdy,
  input  logic [APP_DATA_W-1:0] i_app_rd_data,
  input  logic                  i_app_rd_data_valid,
  output logic [APP_ADDR_W-1:0] o_app_addr,
  output logic [2:0]            o_app_cmd,
  output logic                  o_app_en,
  output logic [APP_DATA_W-1:0] o_app_wdf_data,
  output logic                  o_app_wdf_wren,
  output logic                  o_app_wdf_end,
  output logic                  o_pass,
  output logic                  o_fail,
  output logic [2:0]            o_state
);

  localparam int IDX_W = $clog2(TEST_WORDS) + 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(TEST_WORDS - 1);

  tgen_state_t      r_state;
  tgen_state_t      w_next;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] r_rcnt;
  logic             r_cmd_done;
  logic             r_data_done;
  logic             r_pass;
  logic             r_fail;
  logic             w_cmd_ok;
  logic             w_data_ok;
  logic             w_last_idx;
  logic             w_rd_acc;
  logic             w_rd_cmp;
  logic             w_rd_bad;
  logic             w_last_beat;

  assign o_app_en       = i_calib && (((r_state == WR) && !r_cmd_done) || (r_state == RD));
  assign o_app_cmd      = (r_state == RD) ? APP_CMD_RD : APP_CMD_WR;
  assign o_app_addr     = APP_ADDR_W'(r_idx) << 3;
  assign o_app_wdf_wren = i_calib && (r_state == WR) && !r_data_done;
  assign o_app_wdf_end  = o_app_wdf_wren;
  assign o_app_wdf_data = APP_DATA_W'(pattern_word(SEED, 32'(r_idx)));
  assign o_pass         = r_pass;
  assign o_fail         = r_fail;
  assign o_state        = r_state;

  // Command and data each hold until accepted; the index moves once both are.
  assign w_cmd_ok    = r_cmd_done || (o_app_en && i_app_rdy);
  assign w_data_ok   = r_data_done || (o_app_wdf_wren && i_app_wdf_rdy);
  assign w_last_idx  = (r_idx == LAST);
  assign w_rd_acc    = (r_state == RD) && o_app_en && i_app_rdy;
  assign w_rd_cmp    = i_calib && i_app_rd_data_valid && ((r_state == RD) || (r_state == WAIT_RD));
  assign w_rd_bad    = i_app_rd_data != APP_DATA_W'(pattern_word(SEED, 32'(r_rcnt)));
  assign w_last_beat = w_rd_cmp && (r_rcnt == LAST);

  always_comb begin
    w_next = r_state;
    if (!i_calib) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE:    w_next = WR;
        WR:      if (w_cmd_ok && w_data_ok && w_last_idx) w_next = RD;
        RD:      if (w_rd_acc && w_last_idx) w_next = WAIT_RD;
        WAIT_RD: if (w_last_beat) w_next = DONE;
        default: w_next = r_state;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_rcnt      <= '0;
      r_cmd_done  <= 1'b0;
      r_data_done <= 1'b0;
      r_pass      <= 1'b0;
      r_fail      <= 1'b0;
    end else begin
      r_state <= w_next;
      if (!i_calib) begin
        r_idx       <= '0;
        r_rcnt      <= '0;
        r_cmd_done  <= 1'b0;
        r_data_done <= 1'b0;
      end else begin
        if (r_state == WR) begin
          if (w_cmd_ok && w_data_ok) begin
            r_idx       <= w_last_idx ? '0 : r_idx + IDX_W'(1);
            r_cmd_done  <= 1'b0;
            r_data_done <= 1'b0;
          end else begin
            r_cmd_done  <= w_cmd_ok;
            r_data_done <= w_data_ok;
          end
        end
        if (w_rd_acc) r_idx <= r_idx + IDX_W'(1);
        if (w_rd_cmp) begin
          r_rcnt <= r_rcnt + IDX_W'(1);
          if (w_rd_bad) r_fail <= 1'b1;
          if (w_last_beat) r_pass <= !(r_fail || w_rd_bad);
        end
      end
    end
  end

endmodule

// File: rtl/mig_7series_0.sv
// Behavioural stand-in for the vendor 7-series DDR3 controller: app interface
// with calibration delay, periodic back-pressure and a 16-burst store.
module mig_7series_0 (
  inout  wire  [15:0]  ddr3_dq,
  inout  wire  [1:0]   ddr3_dqs_p,
  inout  wire  [1:0]   ddr3_dqs_n,
  output logic [13:0]  ddr3_addr,
  output logic [2:0]   ddr3_ba,
  output logic         ddr3_ras_n,
  output logic         ddr3_cas_n,
  output logic         ddr3_we_n,
  output logic         ddr3_reset_n,
  output logic         ddr3_ck_p,
  output logic         ddr3_ck_n,
  output logic         ddr3_cke,
  output logic         ddr3_cs_n,
  output logic         ddr3_odt,
  input  logic         sys_clk_i,
  input  logic         sys_rst,
  input  logic [27:0]  app_addr,
  input  logic [2:0]   app_cmd,
  input  logic         app_en,
  input  logic [127:0] app_wdf_data,
  input  logic         app_wdf_end,
  input  logic         app_wdf_wren,
  input  logic [15:0]  app_wdf_mask,
  input  logic         app_sr_req,
  input  logic         app_ref_req,
  input  logic         app_zq_req,
  output logic [127:0] app_rd_data,
  output logic         app_rd_data_valid,
  output logic         app_rdy,
  output logic         app_wdf_rdy,
  output logic         ui_clk,
  output logic         ui_clk_sync_rst,
  output logic         init_calib_complete
);

  localparam int CAL_CYCLES = 20;

  logic [1:0]   r_rst_pipe;
  logic [4:0]   r_cal_cnt;
  logic         r_cal;
  logic         r_reset_n;
  logic         r_cke;
  logic [1:0]   r_bp;
  logic [127:0] r_mem [0:15];
  logic         r_wa_v;
  logic         r_wd_v;
  logic [3:0]   r_wa;
  logic [127:0] r_wd;
  logic [3:0]   r_rd_v;
  logic [3:0]   r_rd_a [0:3];
  logic         w_wa_acc;
  logic         w_wd_acc;
  logic         w_rd_acc;
  logic         w_have_a;
  logic         w_have_d;
  logic         w_commit;
  logic [3:0]   w_a;
  logic [127:0] w_d;
  logic         w_unused;

  assign ui_clk              = sys_clk_i;
  assign ui_clk_sync_rst     = r_rst_pipe[1];
  assign init_calib_complete = r_cal;

  always_ff @(posedge sys_clk_i or negedge sys_rst) begin
    if (!sys_rst) r_rst_pipe <= 2'b11;
    else          r_rst_pipe <= {r_rst_pipe[0], 1'b0};
  end

  always_ff @(posedge sys_clk_i or posedge ui_clk_sync_rst) begin
    if (ui_clk_sync_rst) begin
      r_cal_cnt <= '0;
      r_cal     <= 1'b0;
      r_reset_n <= 1'b0;
      r_cke     <= 1'b0;
      r_bp      <= '0;
      r_wa_v    <= 1'b0;
      r_wd_v    <= 1'b0;
      r_rd_v    <= '0;
    end else begin
      r_reset_n <= 1'b1;
      r_cke     <= r_reset_n;
      r_bp      <= r_bp + 2'd1;
      if (!r_cal) begin
        r_cal_cnt <= r_cal_cnt + 5'd1;
        if (r_cal_cnt == 5'(CAL_CYCLES - 1)) r_cal <= 1'b1;
      end
      r_wa_v <= w_have_a && !w_commit;
      r_wd_v <= w_have_d && !w_commit;
      r_rd_v <= {r_rd_v[2:0], w_rd_acc};
    end
  end

  // Command and data halves of a write may arrive in either order; pair them.
  assign w_wa_acc = app_en && app_rdy && (app_cmd == 3'b000);
  assign w_wd_acc = app_wdf_wren && app_wdf_rdy;
  assign w_rd_acc = app_en && app_rdy && (app_cmd == 3'b001);
  assign w_have_a = r_wa_v || w_wa_acc;
  assign w_have_d = r_wd_v || w_wd_acc;
  assign w_commit = w_have_a && w_have_d;
  assign w_a      = r_wa_v ? r_wa : app_addr[6:3];
  assign w_d      = r_wd_v ? r_wd : app_wdf_data;

  always_ff @(posedge sys_clk_i) begin
    if (w_wa_acc) r_wa <= app_addr[6:3];
    if (w_wd_acc) r_wd <= app_wdf_data;
    if (w_commit) r_mem[w_a] <= w_d;
    r_rd_a[0] <= app_addr[6:3];
    for (int s = 1; s < 4; s++) r_rd_a[s] <= r_rd_a[s-1];
  end

  assign app_rdy           = r_cal && (r_bp != 2'd3);
  assign app_wdf_rdy       = r_cal && (r_bp != 2'd1);
  assign app_rd_data_valid = r_rd_v[3];
  assign app_rd_data       = r_mem[r_rd_a[3]];

  assign ddr3_addr    = '0;
  assign ddr3_ba      = '0;
  assign ddr3_ras_n   = 1'b1;
  assign ddr3_cas_n   = 1'b1;
  assign ddr3_we_n    = 1'b1;
  assign ddr3_reset_n = r_reset_n;
  assign ddr3_ck_p    = 1'b0;
  assign ddr3_ck_n    = 1'b1;
  assign ddr3_cke     = r_cke;
  assign ddr3_cs_n    = ~r_cke;
  assign ddr3_odt     = 1'b0;
  assign ddr3_dq      = 16'bz;
  assign ddr3_dqs_p   = 2'bz;
  assign ddr3_dqs_n   = 2'bz;

  assign w_unused = ^{app_addr[27:7], app_addr[2:0], app_wdf_end, app_wdf_mask,
                      app_sr_req, app_ref_req, app_zq_req};

endmodule

// File: rtl/arty_mig_top.sv
// Arty board top: DDR3 controller behind the board pins, reset synchronizer,
// self-test engine, heartbeat and registered status LEDs.
module arty_mig_top
  import arty_mig_pkg::*;
#(
  parameter int          APP_ADDR_W = APP_ADDR_W_DEF,
  parameter int          APP_DATA_W = APP_DATA_W_DEF,
  parameter int          TEST_WORDS = 16,
  parameter logic [31:0] SEED       = 32'hA5A5_0000,
  parameter int          HB_BITS    = 26
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  inout  wire  [15:0] ddr3_dq,
  inout  wire  [1:0]  ddr3_dqs_p,
  inout  wire  [1:0]  ddr3_dqs_n,
  output logic [13:0] ddr3_addr,
  output logic [2:0]  ddr3_ba,
  output logic        ddr3_ras_n,
  output logic        ddr3_cas_n,
  output logic        ddr3_we_n,
  output logic        ddr3_reset_n,
  output logic        ddr3_ck_p,
  output logic        ddr3_ck_n,
  output logic        ddr3_cke,
  output logic        ddr3_cs_n,
  output logic [1:0]  ddr3_dm,
  output logic        ddr3_odt,
  output logic [3:0]  led
);

  logic                  w_ui_clk;
  logic                  w_ui_clk_sync_rst;
  logic                  init_calib_complete;
  logic                  w_user_rst;
  logic [1:0]            r_rst_sync;
  logic [APP_ADDR_W-1:0] w_app_addr;
  logic [2:0]            w_app_cmd;
  logic                  w_app_en;
  logic [APP_DATA_W-1:0] w_app_wdf_data;
  logic                  w_app_wdf_wren;
  logic                  w_app_wdf_end;
  logic [APP_DATA_W-1:0] w_app_rd_data;
  logic                  w_app_rd_data_valid;
  logic                  w_app_rdy;
  logic                  w_app_wdf_rdy;
  logic                  w_pass;
  logic                  w_fail;
  logic [2:0]            w_tgen_state;
  logic                  w_unused_state;
  logic [HB_BITS-1:0]    r_hb;
  logic [3:0]            r_led;

  assign ddr3_dm = 2'b00;

  mig_7series_0 u_mig (
    .ddr3_dq             (ddr3_dq),
    .ddr3_dqs_p          (ddr3_dqs_p),
    .ddr3_dqs_n          (ddr3_dqs_n),
    .ddr3_addr           (ddr3_addr),
    .ddr3_ba             (ddr3_ba),
    .ddr3_ras_n          (ddr3_ras_n),
    .ddr3_cas_n          (ddr3_cas_n),
    .ddr3_we_n           (ddr3_we_n),
    .ddr3_reset_n        (ddr3_reset_n),
    .ddr3_ck_p           (ddr3_ck_p),
    .ddr3_ck_n           (ddr3_ck_n),
    .ddr3_cke            (ddr3_cke),
    .ddr3_cs_n           (ddr3_cs_n),
    .ddr3_odt            (ddr3_odt),
    .sys_clk_i           (sys_clk),
    .sys_rst             (~sys_rst),
    .app_addr            (w_app_addr),
    .app_cmd             (w_app_cmd),
    .app_en              (w_app_en),
    .app_wdf_data        (w_app_wdf_data),
    .app_wdf_end         (w_app_wdf_end),
    .app_wdf_wren        (w_app_wdf_wren),
    .app_wdf_mask        (16'h0000),
    .app_sr_req          (1'b0),
    .app_ref_req         (1'b0),
    .app_zq_req          (1'b0),
    .app_rd_data         (w_app_rd_data),
    .app_rd_data_valid   (w_app_rd_data_valid),
    .app_rdy             (w_app_rdy),
    .app_wdf_rdy         (w_app_wdf_rdy),
    .ui_clk              (w_ui_clk),
    .ui_clk_sync_rst     (w_ui_clk_sync_rst),
    .init_calib_complete (init_calib_complete)
  );

  // Board reset asserts immediately but releases only on ui_clk.
  always_ff @(posedge w_ui_clk or posedge sys_rst) begin
    if (sys_rst) r_rst_sync <= 2'b11;
    else         r_rst_sync <= {r_rst_sync[0], 1'b0};
  end

  assign w_user_rst = w_ui_clk_sync_rst | r_rst_sync[1];

  arty_mig_tgen #(
    .APP_ADDR_W (APP_ADDR_W),
    .APP_DATA_W (APP_DATA_W),
    .TEST_WORDS (TEST_WORDS),
    .SEED       (SEED)
  ) u_tgen (
    .i_clk               (w_ui_clk),
    .i_rst               (w_user_rst),
    .i_calib             (init_calib_complete),
    .i_app_rdy           (w_app_rdy),
    .i_app_wdf_rdy       (w_app_wdf_rdy),
    .i_app_rd_data       (w_app_rd_data),
    .i_app_rd_data_valid (w_app_rd_data_valid),
    .o_app_addr          (w_app_addr),
    .o_app_cmd           (w_app_cmd),
    .o_app_en            (w_app_en),
    .o_app_wdf_data      (w_app_wdf_data),
    .o_app_wdf_wren      (w_app_wdf_wren),
    .o_app_wdf_end       (w_app_wdf_end),
    .o_pass              (w_pass),
    .o_fail              (w_fail),
    .o_state             (w_tgen_state)
  );

  assign w_unused_state = ^w_tgen_state;

  always_ff @(posedge w_ui_clk or posedge w_user_rst) begin
    if (w_user_rst) begin
      r_hb  <= '0;
      r_led <= '0;
    end else begin
      r_hb  <= r_hb + HB_BITS'(1);
      r_led <= {r_hb[HB_BITS-1], w_fail, w_pass, init_calib_complete};
    end
  end

  assign led = r_led;

endmodule

// File: tb/tb_arty_mig_top.sv
// Directed bench for arty_mig_top: reset, full self-test traffic, heartbeat,
// command back-pressure, corrupted read data and reset in mid-write.
module tb_arty_mig_top;
  import arty_mig_pkg::*;

  localparam logic [31:0] SEED = 32'hA5A5_0000;
  localparam int          TW   = 16;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b0;
  wire  [15:0] ddr3_dq;
  wire  [1:0]  ddr3_dqs_p;
  wire  [1:0]  ddr3_dqs_n;
  logic [13:0] ddr3_addr;
  logic [2:0]  ddr3_ba;
  logic        ddr3_ras_n;
  logic        ddr3_cas_n;
  logic        ddr3_we_n;
  logic        ddr3_reset_n;
  logic        ddr3_ck_p;
  logic        ddr3_ck_n;
  logic        ddr3_cke;
  logic        ddr3_cs_n;
  logic [1:0]  ddr3_dm;
  logic        ddr3_odt;
  logic [3:0]  led;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [30:0]  exp_q[$];
  logic [30:0]  cmd_obs_q[$];
  logic [127:0] wr_obs_q[$];
  logic [127:0] rd_obs_q[$];
  int           hold_viol = 0;
  logic         pend = 1'b0;
  logic [30:0]  pend_word = '0;

  arty_mig_top #(.HB_BITS(4)) dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .ddr3_dq      (ddr3_dq),
    .ddr3_dqs_p   (ddr3_dqs_p),
    .ddr3_dqs_n   (ddr3_dqs_n),
    .ddr3_addr    (ddr3_addr),
    .ddr3_ba      (ddr3_ba),
    .ddr3_ras_n   (ddr3_ras_n),
    .ddr3_cas_n   (ddr3_cas_n),
    .ddr3_we_n    (ddr3_we_n),
    .ddr3_reset_n (ddr3_reset_n),
    .ddr3_ck_p    (ddr3_ck_p),
    .ddr3_ck_n    (ddr3_ck_n),
    .ddr3_cke     (ddr3_cke),
    .ddr3_cs_n    (ddr3_cs_n),
    .ddr3_dm      (ddr3_dm),
    .ddr3_odt     (ddr3_odt),
    .led          (led)
  );

  // ---------------- clock / reset ----------------
  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc++;

  // ---------------- monitor: accepted app traffic ----------------
  always @(negedge sys_clk) begin
    if (!dut.w_user_rst) begin
      if (pend && !(dut.w_app_en && ({dut.w_app_cmd, dut.w_app_addr} == pend_word)))
        hold_viol++;
      pend      = dut.w_app_en && !dut.w_app_rdy;
      pend_word = {dut.w_app_cmd, dut.w_app_addr};
      if (dut.w_app_en && dut.w_app_rdy) cmd_obs_q.push_back({dut.w_app_cmd, dut.w_app_addr});
      if (dut.w_app_wdf_wren && dut.w_app_wdf_rdy) wr_obs_q.push_back(dut.w_app_wdf_data);
      if (dut.w_app_rd_data_valid &&
          ((dut.w_tgen_state == RD) || (dut.w_tgen_state == WAIT_RD)))
        rd_obs_q.push_back(dut.w_app_rd_data);
    end else begin
      pend = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_obs();
    cmd_obs_q.delete();
    wr_obs_q.delete();
    rd_obs_q.delete();
    hold_viol = 0;
  endtask

  task automatic restart();
    @(negedge sys_clk);
    sys_rst = 1'b1;
    repeat (2) @(negedge sys_clk);
    clear_obs();
    sys_rst = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] st, input int budget, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge sys_clk);
      if (dut.w_tgen_state == st) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  function automatic logic [127:0] exp_data(input int k);
    logic [31:0] w;
    w = SEED + 32'(k);
    return {w, w, w, w};
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    bit seen;
    #1 sys_rst = 1'b1;
    #10;
    checks++;
    if (led !== 4'b0000) begin
      errors++; $display("FAIL reset_led: got %b want 0000", led);
    end
    checks++;
    if (dut.w_tgen_state !== 3'(IDLE)) begin
      errors++; $display("FAIL reset_state: got %0d want %0d", dut.w_tgen_state, IDLE);
    end
    checks++;
    if (dut.w_app_en !== 1'b0 || dut.w_app_wdf_wren !== 1'b0) begin
      errors++; $display("FAIL reset_app_en: en %b wren %b want 0 0", dut.w_app_en, dut.w_app_wdf_wren);
    end
    checks++;
    if (ddr3_reset_n !== 1'b0 || ddr3_cke !== 1'b0 || ddr3_cs_n !== 1'b1 || ddr3_dm !== 2'b00) begin
      errors++; $display("FAIL reset_pins: reset_n %b cke %b cs_n %b dm %b want 0 0 1 00",
                         ddr3_reset_n, ddr3_cke, ddr3_cs_n, ddr3_dm);
    end
    @(negedge sys_clk);
    sys_rst = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge sys_clk);
      if (dut.init_calib_complete === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL calib_timeout: init_calib_complete never rose within 100 cycles");
    end
    checks++;
    if (led[0] !== 1'b0) begin
      errors++; $display("FAIL led0_latency: got %b in calib cycle want 0", led[0]);
    end
    @(negedge sys_clk);
    checks++;
    if (led[0] !== 1'b1) begin
      errors++; $display("FAIL led0_calib: got %b want 1", led[0]);
    end
    checks++;
    if (ddr3_reset_n !== 1'b1 || ddr3_cke !== 1'b1) begin
      errors++; $display("FAIL pins_after_cal: reset_n %b cke %b want 1 1", ddr3_reset_n, ddr3_cke);
    end
  endtask

  task automatic test_traffic();
    bit ok;
    wait_state(3'(DONE), 2000, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL traffic_done_timeout: state %0d want %0d", dut.w_tgen_state, DONE);
    end
    repeat (3) @(negedge sys_clk);
    exp_q.delete();
    for (int i = 0; i < TW; i++) exp_q.push_back({3'b000, 28'(i * 8)});
    for (int i = 0; i < TW; i++) exp_q.push_back({3'b001, 28'(i * 8)});
    checks++;
    if (cmd_obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL traffic_cmd_count: got %0d want %0d", cmd_obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < cmd_obs_q.size(); i++) begin
      checks++;
      if (cmd_obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL traffic_cmd[%0d]: got %h want %h", i, cmd_obs_q[i], exp_q[i]);
      end
    end
    checks++;
    if (wr_obs_q.size() != TW) begin
      errors++; $display("FAIL traffic_wdata_count: got %0d want %0d", wr_obs_q.size(), TW);
    end
    for (int i = 0; i < TW && i < wr_obs_q.size(); i++) begin
      checks++;
      if (wr_obs_q[i] !== exp_data(i)) begin
        errors++; $display("FAIL traffic_wdata[%0d]: got %h want %h", i, wr_obs_q[i], exp_data(i));
      end
    end
    checks++;
    if (rd_obs_q.size() != TW) begin
      errors++; $display("FAIL traffic_rdata_count: got %0d want %0d", rd_obs_q.size(), TW);
    end
    for (int i = 0; i < TW && i < rd_obs_q.size(); i++) begin
      checks++;
      if (rd_obs_q[i] !== exp_data(i)) begin
        errors++; $display("FAIL traffic_rdata[%0d]: got %h want %h", i, rd_obs_q[i], exp_data(i));
      end
    end
    checks++;
    if (led[2:0] !== 3'b011) begin
      errors++; $display("FAIL traffic_leds: got %b want 011", led[2:0]);
    end
    checks++;
    if (dut.w_app_en !== 1'b0 || dut.w_app_wdf_wren !== 1'b0) begin
      errors++; $display("FAIL done_quiet: en %b wren %b want 0 0", dut.w_app_en, dut.w_app_wdf_wren);
    end
  endtask

  task automatic test_heartbeat();
    logic prev;
    int   t_prev;
    int   t_now;
    bit   seen;
    t_prev = 0;
    for (int e = 0; e < 3; e++) begin
      prev = led[3];
      seen = 1'b0;
      for (int n = 0; n < 40; n++) begin
        @(negedge sys_clk);
        if (led[3] !== prev) begin
          seen = 1'b1;
          break;
        end
      end
      t_now = cyc;
      checks++;
      if (!seen) begin
        errors++; $display("FAIL hb_toggle_timeout: led[3] stuck at %b", prev);
      end else if (e > 0) begin
        checks++;
        if (t_now - t_prev != 8) begin
          errors++; $display("FAIL hb_period: got %0d cycles want 8", t_now - t_prev);
        end
      end
      t_prev = t_now;
    end
  endtask

  task automatic test_back_pressure();
    bit          ok;
    logic [27:0] held_addr;
    restart();
    wait_state(3'(WR), 200, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL bp_wr_timeout: state %0d want %0d", dut.w_tgen_state, WR);
    end
    repeat (3) @(negedge sys_clk);
    force dut.w_app_rdy = 1'b0;
    repeat (5) @(negedge sys_clk);
    held_addr = dut.w_app_addr;
    repeat (45) @(negedge sys_clk);
    checks++;
    if (dut.w_app_en !== 1'b1 || dut.w_app_addr !== held_addr || dut.w_tgen_state !== 3'(WR)) begin
      errors++; $display("FAIL bp_hold: en %b addr %h state %0d want 1 %h %0d",
                         dut.w_app_en, dut.w_app_addr, dut.w_tgen_state, held_addr, WR);
    end
    release dut.w_app_rdy;
    wait_state(3'(DONE), 2000, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL bp_done_timeout: state %0d want %0d", dut.w_tgen_state, DONE);
    end
    repeat (3) @(negedge sys_clk);
    checks++;
    if (hold_viol != 0) begin
      errors++; $display("FAIL bp_hold_violations: got %0d want 0", hold_viol);
    end
    exp_q.delete();
    for (int i = 0; i < TW; i++) exp_q.push_back({3'b000, 28'(i * 8)});
    for (int i = 0; i < TW; i++) exp_q.push_back({3'b001, 28'(i * 8)});
    checks++;
    if (cmd_obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL bp_cmd_count: got %0d want %0d", cmd_obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < cmd_obs_q.size(); i++) begin
      checks++;
      if (cmd_obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL bp_cmd[%0d]: got %h want %h", i, cmd_obs_q[i], exp_q[i]);
      end
    end
    checks++;
    if (led[2:1] !== 2'b01) begin
      errors++; $display("FAIL bp_result: fail/pass got %b want 01", led[2:1]);
    end
  endtask

  task automatic test_corrupt_read();
    bit ok;
    restart();
    wait_state(3'(RD), 500, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL corrupt_rd_timeout: state %0d want %0d", dut.w_tgen_state, RD);
    end
    force dut.w_app_rd_data = 128'h0;
    wait_state(3'(DONE), 500, ok);
    release dut.w_app_rd_data;
    checks++;
    if (!ok) begin
      errors++; $display("FAIL corrupt_done_timeout: state %0d want %0d", dut.w_tgen_state, DONE);
    end
    repeat (3) @(negedge sys_clk);
    checks++;
    if (led[2:1] !== 2'b10) begin
      errors++; $display("FAIL corrupt_result: fail/pass got %b want 10", led[2:1]);
    end
    checks++;
    if (dut.w_tgen_state !== 3'(DONE)) begin
      errors++; $display("FAIL corrupt_state: got %0d want %0d", dut.w_tgen_state, DONE);
    end
  endtask

  task automatic test_reset_mid_wr();
    bit ok;
    restart();
    wait_state(3'(WR), 200, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL midrst_wr_timeout: state %0d want %0d", dut.w_tgen_state, WR);
    end
    repeat (4) @(negedge sys_clk);
    #1 sys_rst = 1'b1;
    #1;
    checks++;
    if (led !== 4'b0000) begin
      errors++; $display("FAIL midrst_led: got %b want 0000", led);
    end
    checks++;
    if (dut.w_tgen_state !== 3'(IDLE) || dut.w_app_en !== 1'b0) begin
      errors++; $display("FAIL midrst_state: state %0d en %b want %0d 0", dut.w_tgen_state, dut.w_app_en, IDLE);
    end
    @(negedge sys_clk);
    clear_obs();
    sys_rst = 1'b0;
    wait_state(3'(DONE), 2000, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL midrst_done_timeout: state %0d want %0d", dut.w_tgen_state, DONE);
    end
    repeat (3) @(negedge sys_clk);
    checks++;
    if (led[2:0] !== 3'b011) begin
      errors++; $display("FAIL midrst_result: got %b want 011", led[2:0]);
    end
    checks++;
    if (cmd_obs_q.size() != 2 * TW) begin
      errors++; $display("FAIL midrst_cmd_count: got %0d want %0d", cmd_obs_q.size(), 2 * TW);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_traffic();
    test_heartbeat();
    test_back_pressure();
    test_corrupt_read();
    test_reset_mid_wr();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/arty_mig_top.md
Name: arty_mig_top

Overview:
- FPGA top for the Arty board.
- Wraps the vendor-generated 7-series DDR3 memory controller (instance u_mig, external IP, not counted in RTL size) behind the board pins.
- Adds a small self-test traffic engine and LED status logic.
- Simulated against a DDR3 behavioural memory model and the vendor global-signal module.

Parameters:
- APP_ADDR_W, 28, controller app_addr width.
- APP_DATA_W, 128, controller app data width (x16 DDR3, 4:1, BL8).
- TEST_WORDS, 16, number of bursts written then read back.
- SEED, 32'hA5A5_0000, data pattern seed.
- HB_BITS, 26, heartbeat counter width.

Ports:
- sys_clk  in  1  100 MHz board clock; only clock input.
- sys_rst  in  1  asynchronous, active-high reset.
- ddr3_dq  inout  16  DRAM data.
- ddr3_dqs_p / ddr3_dqs_n  inout  2  data strobes.
- ddr3_addr  out  14  row/column address.
- ddr3_ba  out  3  bank address.
- ddr3_ras_n / ddr3_cas_n / ddr3_we_n  out  1  command pins.
- ddr3_reset_n  out  1  DRAM reset.
- ddr3_ck_p / ddr3_ck_n  out  1  differential DRAM clock.
- ddr3_cke  out  1  clock enable.
- ddr3_cs_n  out  1  chip select.
- ddr3_dm  out  2  data mask; driven 0.
- ddr3_odt  out  1  on-die termination.
- led  out  4  status.

Behaviour:
- Clocking and reset:
  - sys_clk feeds u_mig sys_clk_i, no input buffer; controller reference clock is set to "use system clock".
  - Controller reset input is active-low and is driven by ~sys_rst.
  - All user logic runs on ui_clk and is reset by (ui_clk_sync_rst | sys_rst). sys_rst is asserted asynchronously and released through a 2-flop synchronizer.
- Top-level net init_calib_complete (exact name, probed hierarchically by benches) carries the controller calibration-done flag.
- Reset values: led=0; FSM=IDLE; all app_* enables=0; counters=0; pass=0; fail=0.
- FSM states and transitions:
  - IDLE: wait for init_calib_complete=1, then go to WR.
  - WR: issue TEST_WORDS writes with app_cmd=3'b000 at address i*8 (i=0..TEST_WORDS-1). Data = {4{SEED+i}}.
  - WR command/data completion: app_en stays high until app_rdy=1. app_wdf_wren and app_wdf_end both stay high until app_wdf_rdy=1. Command and data may complete in either order. Index i advances only after both have completed.
  - After the last write, go to RD.
  - RD: issue TEST_WORDS reads with app_cmd=3'b001 at the same addresses, same app_en/app_rdy rule. Go to WAIT_RD after the last read command is accepted.
  - Read data return (states RD and WAIT_RD): each app_rd_data_valid beat is compared in order against expected {4{SEED+k}}, where k is the return counter. Any mismatch sets fail (sticky).
  - When k reaches TEST_WORDS, go to DONE. pass=~fail.
  - DONE: terminal until reset; no further app traffic.
- Calibration loss (init_calib_complete drops) in any state: return to IDLE and clear counters. pass/fail are retained.
- Unused controller inputs: app_wdf_mask=0; app_sr_req, app_ref_req, app_zq_req=0.
- LEDs, each registered one cycle:
  - led[0] = init_calib_complete.
  - led[1] = pass.
  - led[2] = fail.
  - led[3] = MSB of a free-running HB_BITS counter (wraps).
- Reset asserted mid-test: state returns to IDLE asynchronously; the test reruns after recalibration.

Decomposition:
- Package arty_mig_pkg holds:
  - APP_CMD_WR=3'b000, APP_CMD_RD=3'b001.
  - State enum (IDLE, WR, RD, WAIT_RD, DONE).
  - Address/data width constants.
- One sub-module: arty_mig_tgen, containing the FSM, the pattern generator/checker and the pass/fail flags on the controller app interface.
- The top holds u_mig, the reset synchronizer, the heartbeat counter and the LED registers.

Test Plan:
- sys_rst=1 for 10 ns, then 0 → init_calib_complete rises; led[0]=1 one ui_clk later; all DDR3 pins toggle only after ddr3_reset_n=1.
- After calibration, run 1 µs with the DDR3 model attached → 16 writes then 16 reads observed; led[1]=1, led[2]=0; read data k = {4{32'hA5A5_0000+k}}.
- Force app_rdy low for 50 cycles during WR → app_en held steady, no address skipped, final result still pass.
- Corrupt ddr3_dq[0] stuck at 0 during RD → led[2]=1, led[1]=0, FSM reaches DONE.
- Assert sys_rst in the middle of WR → led=0 immediately; after release and recalibration the test completes with led[1]=1.
- Heartbeat with HB_BITS reduced to 4 → led[3] toggles every 8 ui_clk cycles.
